// File: rtl/tlul_pkg.sv
// TL-UL bus widths, opcode enums and channel payload structs shared by device adapters.
package tlul_pkg;

    localparam int unsigned TL_AW  = 32;
    localparam int unsigned TL_DW  = 32;
    localparam int unsigned TL_DBW = TL_DW / 8;
    localparam int unsigned TL_SZW = 2;
    localparam int unsigned TL_AIW = 8;
    localparam int unsigned TL_DIW = 1;
    localparam int unsigned TL_AUW = 16;
    localparam int unsigned TL_DUW = 16;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic                a_valid;
        tl_a_op_e            a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic [TL_AUW-1:0]   a_user;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        tl_d_op_e            d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        logic [TL_DUW-1:0]   d_user;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_req_chk.sv
// Combinational TL-UL A-channel legality checker for 32-bit device ports.
module tlul_req_chk
    import tlul_pkg::*;
(
    input  logic [2:0]        opcode_i,
    input  logic [TL_SZW-1:0] size_i,
    input  logic [1:0]        addr_i,
    input  logic [TL_DBW-1:0] mask_i,
    output logic              err_o
);

    logic [TL_DBW-1:0] lanes;
    logic              is_full;
    logic              is_write;
    logic              op_bad;
    logic              size_bad;
    logic              align_bad;
    logic              mask_bad;
    logic              full_bad;
    logic              zero_bad;

    // Byte lanes addressed by size/offset, then each illegality term.
    always_comb begin
        lanes = '0;
        case (size_i)
            2'd0:    lanes = TL_DBW'(1) << addr_i;
            2'd1:    lanes = addr_i[1] ? TL_DBW'(4'b1100) : TL_DBW'(4'b0011);
            2'd2:    lanes = TL_DBW'(4'b1111);
            default: lanes = '0;
        endcase

        is_full   = (opcode_i == PutFullData);
        is_write  = is_full || (opcode_i == PutPartialData);
        op_bad    = !(is_write || (opcode_i == Get));
        size_bad  = (size_i > 2'd2);
        align_bad = ((size_i == 2'd1) && addr_i[0]) ||
                    ((size_i == 2'd2) && (addr_i != 2'b00));
        mask_bad  = |(mask_i & ~lanes);
        full_bad  = is_full && (mask_i != lanes);
        zero_bad  = is_write && (mask_i == '0);

        err_o = op_bad | size_bad | align_bad | mask_bad | full_bad | zero_bad;
    end

endmodule

// File: rtl/tlul_adapter_reg_lite.sv
// TL-UL device endpoint: one transaction in flight, single-cycle register strobes.
module tlul_adapter_reg_lite
    import tlul_pkg::*;
#(
    parameter int unsigned RegAw         = 8,
    parameter int unsigned AccessLatency = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  tl_h2d_t           tl_i,
    output tl_d2h_t           tl_o,
    output logic              re_o,
    output logic              we_o,
    output logic [RegAw-1:0]  addr_o,
    output logic [TL_DW-1:0]  wdata_o,
    output logic [TL_DBW-1:0] be_o,
    input  logic [TL_DW-1:0]  rdata_i,
    input  logic              error_i
);

    if (AccessLatency > 1) begin : gen_bad_latency
        $error("tlul_adapter_reg_lite: AccessLatency must be 0 or 1");
    end

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e             state_q;
    tl_d_op_e           d_opcode_q;
    logic [TL_SZW-1:0]  d_size_q;
    logic [TL_AIW-1:0]  d_source_q;
    logic [TL_DW-1:0]   d_data_q;
    logic               d_error_q;
    logic               rd_pend_q;
    logic               acc_pend_q;

    logic a_ready_c;
    logic accept_c;
    logic req_err_c;
    logic is_get_c;
    logic is_put_c;
    logic unused_c;

    tlul_req_chk u_req_chk (
        .opcode_i (tl_i.a_opcode),
        .size_i   (tl_i.a_size),
        .addr_i   (tl_i.a_address[1:0]),
        .mask_i   (tl_i.a_mask),
        .err_o    (req_err_c)
    );

    // Handshake and strobe decode; reset blocks acceptance so no strobe fires in a reset cycle.
    assign a_ready_c = (state_q == StIdle) && !rst_i;
    assign accept_c  = tl_i.a_valid && a_ready_c;
    assign is_get_c  = (tl_i.a_opcode == Get);
    assign is_put_c  = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    assign re_o      = accept_c && !req_err_c && is_get_c;
    assign we_o      = accept_c && !req_err_c && is_put_c;
    assign addr_o    = {tl_i.a_address[RegAw-1:2], 2'b00};
    assign wdata_o   = tl_i.a_data;
    assign be_o      = tl_i.a_mask;
    assign unused_c  = ^{tl_i.a_param, tl_i.a_user, tl_i.a_address[TL_AW-1:RegAw]};

    // FSM and response register: capture at accept, sample register data at the latency point.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            d_opcode_q <= AccessAck;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_data_q   <= '0;
            d_error_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            acc_pend_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept_c) begin
                        d_opcode_q <= is_get_c ? AccessAckData : AccessAck;
                        d_size_q   <= tl_i.a_size;
                        d_source_q <= tl_i.a_source;
                        rd_pend_q  <= !req_err_c && is_get_c;
                        acc_pend_q <= !req_err_c;
                        if (req_err_c) begin
                            d_error_q <= 1'b1;
                            d_data_q  <= is_get_c ? '1 : '0;
                        end else if (AccessLatency == 0) begin
                            d_error_q <= error_i;
                            d_data_q  <= is_get_c ? rdata_i : '0;
                        end else begin
                            d_error_q <= 1'b0;
                            d_data_q  <= '0;
                        end
                        state_q <= (AccessLatency == 0) ? StResp : StWait;
                    end
                end
                StWait: begin
                    if (rd_pend_q) begin
                        d_data_q <= rdata_i;
                    end
                    d_error_q <= d_error_q | (acc_pend_q & error_i);
                    state_q   <= StResp;
                end
                StResp: begin
                    if (tl_i.d_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Response channel assembly; unused D fields tie to zero.
    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = a_ready_c;
        tl_o.d_valid  = (state_q == StResp) && !rst_i;
        tl_o.d_opcode = d_opcode_q;
        tl_o.d_size   = d_size_q;
        tl_o.d_source = d_source_q;
        tl_o.d_data   = d_data_q;
        tl_o.d_error  = d_error_q;
    end

endmodule

// File: tb/tb_tlul_adapter_reg_lite.sv
// Directed bench for tlul_adapter_reg_lite: vector table at L=0 plus latency/backpressure/reset sequences.
module tb_tlul_adapter_reg_lite;
    import tlul_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    tl_h2d_t     h2d0, h2d1;
    tl_d2h_t     d2h0, d2h1;
    logic        re0, we0, re1, we1;
    logic [7:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [3:0]  be0, be1;
    logic [31:0] rdata0, rdata1;
    logic        err0, err1;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    tlul_adapter_reg_lite #(.RegAw(8), .AccessLatency(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .tl_i(h2d0), .tl_o(d2h0),
        .re_o(re0), .we_o(we0), .addr_o(addr0), .wdata_o(wdata0), .be_o(be0),
        .rdata_i(rdata0), .error_i(err0)
    );

    tlul_adapter_reg_lite #(.RegAw(8), .AccessLatency(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .tl_i(h2d1), .tl_o(d2h1),
        .re_o(re1), .we_o(we1), .addr_o(addr1), .wdata_o(wdata1), .be_o(be1),
        .rdata_i(rdata1), .error_i(err1)
    );

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  addr;
        logic [3:0]  mask;
        logic [7:0]  src;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err_in;
        logic        exp_re;
        logic        exp_we;
        logic        exp_err;
        logic        exp_dop;
        logic [7:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
            n_miss++;
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [1:0] size, input logic [7:0] addr,
                                input logic [3:0] mask, input logic [7:0] src, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err_in, input logic exp_re,
                                input logic exp_we, input logic exp_err, input logic exp_dop,
                                input logic [7:0] exp_addr, input logic [31:0] exp_data);
        vec_t v;
        v.op = op; v.size = size; v.addr = addr; v.mask = mask; v.src = src;
        v.wdata = wdata; v.rdata = rdata; v.err_in = err_in;
        v.exp_re = exp_re; v.exp_we = exp_we; v.exp_err = exp_err; v.exp_dop = exp_dop;
        v.exp_addr = exp_addr; v.exp_data = exp_data;
        return v;
    endfunction

    function automatic tl_h2d_t req(input logic [2:0] op, input logic [1:0] size, input logic [7:0] addr,
                                    input logic [3:0] mask, input logic [7:0] src, input logic [31:0] wdata);
        tl_h2d_t r;
        r           = '0;
        r.a_valid   = 1'b1;
        r.a_opcode  = tl_a_op_e'(op);
        r.a_size    = size;
        r.a_address = 32'(addr);
        r.a_mask    = mask;
        r.a_source  = src;
        r.a_data    = wdata;
        return r;
    endfunction

    // One table vector on dut0: accept cycle, response cycle, back to idle. Entered at posedge+1.
    task automatic run_vec(input int i, input vec_t v);
        string t;
        t = $sformatf("v%0d", i);
        h2d0   = req(v.op, v.size, v.addr, v.mask, v.src, v.wdata);
        rdata0 = v.rdata;
        err0   = v.err_in;
        #1;
        chk({t, " a_ready"}, 32'(d2h0.a_ready), 32'd1);
        chk({t, " re"}, 32'(re0), 32'(v.exp_re));
        chk({t, " we"}, 32'(we0), 32'(v.exp_we));
        if (v.exp_re || v.exp_we) begin
            chk({t, " addr"}, 32'(addr0), 32'(v.exp_addr));
            chk({t, " be"}, 32'(be0), 32'(v.mask));
        end
        if (v.exp_we) chk({t, " wdata"}, wdata0, v.wdata);
        @(posedge clk); #1;
        h2d0.a_valid = 1'b0;
        h2d0.d_ready = 1'b1;
        rdata0 = 32'h0BAD_0BAD;
        err0   = 1'b1;
        chk({t, " d_valid"}, 32'(d2h0.d_valid), 32'd1);
        chk({t, " a_ready busy"}, 32'(d2h0.a_ready), 32'd0);
        chk({t, " d_opcode"}, 32'(d2h0.d_opcode), 32'(v.exp_dop));
        chk({t, " d_error"}, 32'(d2h0.d_error), 32'(v.exp_err));
        chk({t, " d_data"}, d2h0.d_data, v.exp_data);
        chk({t, " d_size"}, 32'(d2h0.d_size), 32'(v.size));
        chk({t, " d_source"}, 32'(d2h0.d_source), 32'(v.src));
        chk({t, " d_zero"}, 32'({d2h0.d_param, d2h0.d_sink, d2h0.d_user}), 32'd0);
        chk({t, " re resp"}, 32'(re0 | we0), 32'd0);
        @(posedge clk); #1;
        err0 = 1'b0;
        chk({t, " idle d_valid"}, 32'(d2h0.d_valid), 32'd0);
        chk({t, " idle a_ready"}, 32'(d2h0.a_ready), 32'd1);
        n_vec++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //      op  sz  addr   mask src    wdata         rdata         ei re we er dop addr_o exp_data
        vecs[0]  = mk(4, 2, 8'h10, 4'hF, 8'h5A, 32'h0,        32'hDEADBEEF, 0, 1, 0, 0, 1, 8'h10, 32'hDEADBEEF);
        vecs[1]  = mk(1, 0, 8'h06, 4'h4, 8'h01, 32'h00AB0000, 32'h11111111, 0, 0, 1, 0, 0, 8'h04, 32'h0);
        vecs[2]  = mk(1, 0, 8'h06, 4'h1, 8'h02, 32'h000000AB, 32'h11111111, 0, 0, 0, 1, 0, 8'h04, 32'h0);
        vecs[3]  = mk(3, 2, 8'h10, 4'hF, 8'h03, 32'h0,        32'h22222222, 0, 0, 0, 1, 0, 8'h10, 32'h0);
        vecs[4]  = mk(4, 2, 8'h02, 4'hF, 8'h04, 32'h0,        32'h12345678, 0, 0, 0, 1, 1, 8'h00, 32'hFFFFFFFF);
        vecs[5]  = mk(0, 2, 8'h20, 4'hF, 8'h05, 32'h12345678, 32'h33333333, 0, 0, 1, 0, 0, 8'h20, 32'h0);
        vecs[6]  = mk(0, 2, 8'h20, 4'h7, 8'h06, 32'h12345678, 32'h0,        0, 0, 0, 1, 0, 8'h20, 32'h0);
        vecs[7]  = mk(4, 3, 8'h20, 4'hF, 8'h07, 32'h0,        32'h55555555, 0, 0, 0, 1, 1, 8'h20, 32'hFFFFFFFF);
        vecs[8]  = mk(1, 2, 8'h24, 4'h0, 8'h08, 32'h9,        32'h0,        0, 0, 0, 1, 0, 8'h24, 32'h0);
        vecs[9]  = mk(4, 2, 8'h30, 4'hF, 8'h09, 32'h0,        32'hCAFEF00D, 1, 1, 0, 1, 1, 8'h30, 32'hCAFEF00D);
        vecs[10] = mk(1, 2, 8'h30, 4'h3, 8'h0A, 32'h0000BEEF, 32'h44444444, 1, 0, 1, 1, 0, 8'h30, 32'h0);
        vecs[11] = mk(4, 1, 8'h03, 4'h3, 8'h0B, 32'h0,        32'h66666666, 0, 0, 0, 1, 1, 8'h00, 32'hFFFFFFFF);
        vecs[12] = mk(1, 1, 8'h0E, 4'hC, 8'h0C, 32'hA5A50000, 32'h0,        0, 0, 1, 0, 0, 8'h0C, 32'h0);
        vecs[13] = mk(4, 1, 8'h00, 4'h4, 8'h0D, 32'h0,        32'h77777777, 0, 0, 0, 1, 1, 8'h00, 32'hFFFFFFFF);
        vecs[14] = mk(4, 2, 8'hFC, 4'h1, 8'h0E, 32'h0,        32'h00000055, 0, 1, 0, 0, 1, 8'hFC, 32'h00000055);
        vecs[15] = mk(0, 0, 8'h01, 4'h2, 8'h0F, 32'h0000AA00, 32'h0,        0, 0, 1, 0, 0, 8'h00, 32'h0);
        vecs[16] = mk(0, 1, 8'h02, 4'h4, 8'h10, 32'h0,        32'h0,        0, 0, 0, 1, 0, 8'h00, 32'h0);
        vecs[17] = mk(7, 2, 8'h10, 4'hF, 8'h11, 32'h0,        32'h88888888, 0, 0, 0, 1, 0, 8'h10, 32'h0);

        // Reset: requests presented during reset are ignored, response fields clear.
        rst = 1'b1;
        h2d0 = req(3'd4, 2'd2, 8'h10, 4'hF, 8'h5A, 32'h0);
        h2d1 = req(3'd4, 2'd2, 8'h10, 4'hF, 8'h5A, 32'h0);
        rdata0 = '0; rdata1 = '0; err0 = 1'b0; err1 = 1'b0;
        @(posedge clk); #1;
        chk("rst a_ready0", 32'(d2h0.a_ready), 32'd0);
        chk("rst a_ready1", 32'(d2h1.a_ready), 32'd0);
        chk("rst d_valid0", 32'(d2h0.d_valid), 32'd0);
        chk("rst strobes", 32'({re0, we0, re1, we1}), 32'd0);
        h2d0.a_valid = 1'b0;
        h2d1.a_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post-rst a_ready0", 32'(d2h0.a_ready), 32'd1);
        chk("post-rst a_ready1", 32'(d2h1.a_ready), 32'd1);
        chk("post-rst d_valid0", 32'(d2h0.d_valid), 32'd0);
        chk("post-rst d_data0", d2h0.d_data, 32'd0);
        chk("post-rst d_fields0", 32'({d2h0.d_opcode, d2h0.d_size, d2h0.d_source, d2h0.d_error}), 32'd0);
        n_vec++;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

        // AccessLatency=1: read data sampled the cycle after accept.
        h2d1 = req(3'd4, 2'd2, 8'h10, 4'hF, 8'h5A, 32'h0);
        h2d1.d_ready = 1'b0;
        rdata1 = 32'h1;
        #1;
        chk("L1 re", 32'(re1), 32'd1);
        chk("L1 addr", 32'(addr1), 32'h10);
        @(posedge clk); #1;
        h2d1.a_valid = 1'b0;
        rdata1 = 32'h2;
        chk("L1 wait d_valid", 32'(d2h1.d_valid), 32'd0);
        chk("L1 wait a_ready", 32'(d2h1.a_ready), 32'd0);
        chk("L1 wait re", 32'(re1), 32'd0);
        @(posedge clk); #1;
        rdata1 = 32'h3;
        chk("L1 d_valid", 32'(d2h1.d_valid), 32'd1);
        chk("L1 d_data", d2h1.d_data, 32'h2);
        chk("L1 d_opcode", 32'(d2h1.d_opcode), 32'(AccessAckData));
        chk("L1 d_source", 32'(d2h1.d_source), 32'h5A);
        chk("L1 d_error", 32'(d2h1.d_error), 32'd0);
        h2d1.d_ready = 1'b1;
        @(posedge clk); #1;
        chk("L1 idle", 32'({d2h1.d_valid, d2h1.a_ready}), 32'b01);
        n_vec++;

        // AccessLatency=1: error_i counts only at the wait-cycle sample point.
        h2d1 = req(3'd0, 2'd2, 8'h20, 4'hF, 8'h33, 32'hFEEDFACE);
        h2d1.d_ready = 1'b1;
        err1 = 1'b0;
        #1;
        chk("L1 put we", 32'(we1), 32'd1);
        @(posedge clk); #1;
        h2d1.a_valid = 1'b0;
        err1 = 1'b1;
        @(posedge clk); #1;
        err1 = 1'b0;
        chk("L1 put d_valid", 32'(d2h1.d_valid), 32'd1);
        chk("L1 put d_error", 32'(d2h1.d_error), 32'd1);
        chk("L1 put d_data", d2h1.d_data, 32'd0);
        chk("L1 put d_opcode", 32'(d2h1.d_opcode), 32'(AccessAck));
        @(posedge clk); #1;
        chk("L1 put idle", 32'(d2h1.d_valid), 32'd0);
        n_vec++;

        // Backpressure: response held stable, new request ignored until handshake.
        h2d0 = req(3'd4, 2'd2, 8'h10, 4'hF, 8'h21, 32'h0);
        h2d0.d_ready = 1'b0;
        rdata0 = 32'hDEADBEEF;
        #1;
        chk("bp re", 32'(re0), 32'd1);
        @(posedge clk); #1;
        h2d0 = req(3'd0, 2'd2, 8'h20, 4'hF, 8'h22, 32'h01020304);
        h2d0.d_ready = 1'b0;
        rdata0 = 32'h0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d d_valid", k), 32'(d2h0.d_valid), 32'd1);
            chk($sformatf("bp%0d d_data", k), d2h0.d_data, 32'hDEADBEEF);
            chk($sformatf("bp%0d d_source", k), 32'(d2h0.d_source), 32'h21);
            chk($sformatf("bp%0d a_ready", k), 32'(d2h0.a_ready), 32'd0);
            chk($sformatf("bp%0d strobes", k), 32'({re0, we0}), 32'd0);
            @(posedge clk); #1;
        end
        h2d0.d_ready = 1'b1;
        #1;
        chk("bp hs d_valid", 32'(d2h0.d_valid), 32'd1);
        @(posedge clk); #1;
        chk("bp next a_ready", 32'(d2h0.a_ready), 32'd1);
        chk("bp next we", 32'(we0), 32'd1);
        chk("bp next d_valid", 32'(d2h0.d_valid), 32'd0);
        @(posedge clk); #1;
        h2d0.a_valid = 1'b0;
        chk("bp put d_valid", 32'(d2h0.d_valid), 32'd1);
        chk("bp put d_source", 32'(d2h0.d_source), 32'h22);
        chk("bp put d_opcode", 32'(d2h0.d_opcode), 32'(AccessAck));
        @(posedge clk); #1;
        chk("bp idle", 32'(d2h0.d_valid), 32'd0);
        n_vec++;

        // Reset during RESP: response dropped, no strobe in the reset cycle.
        h2d0 = req(3'd4, 2'd2, 8'h10, 4'hF, 8'h44, 32'h0);
        h2d0.d_ready = 1'b0;
        rdata0 = 32'h12345678;
        @(posedge clk); #1;
        chk("rr resp d_valid", 32'(d2h0.d_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rr rst re", 32'(re0), 32'd0);
        chk("rr rst a_ready", 32'(d2h0.a_ready), 32'd0);
        @(posedge clk); #1;
        chk("rr after d_valid", 32'(d2h0.d_valid), 32'd0);
        chk("rr after a_ready", 32'(d2h0.a_ready), 32'd0);
        chk("rr after re", 32'(re0), 32'd0);
        rst = 1'b0;
        h2d0.a_valid = 1'b0;
        h2d0.d_ready = 1'b1;
        #1;
        chk("rr rel a_ready", 32'(d2h0.a_ready), 32'd1);
        chk("rr rel d_valid", 32'(d2h0.d_valid), 32'd0);
        @(posedge clk); #1;
        chk("rr idle d_valid", 32'(d2h0.d_valid), 32'd0);
        chk("rr idle d_data", d2h0.d_data, 32'd0);
        n_vec++;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/tlul_adapter_reg_lite.md
# tlul_adapter_reg_lite

Device-side TL-UL endpoint that sits directly downstream of a TL-UL request/response FIFO pair and converts bus transactions into single-cycle register read/write strobes. It checks each request for legality, drives the register port, captures read data, and returns a TL-UL response. It allows one transaction in flight and hides register access latency behind a small FSM.

## Interface
Parameters:
- RegAw, 8: register address width; `addr_o` = `a_address[RegAw-1:0]`, word-aligned.
- AccessLatency, 0: `rdata_i`/`error_i` sample point. 0 = same cycle as `re_o`/`we_o`; 1 = one cycle later. Other values are illegal; elaboration assertion.

Ports:
- clk_i  in  1  clock; the only clock, all logic on posedge.
- rst_i  in  1  reset, synchronous, active-high.
- tl_i  in  tlul_pkg::tl_h2d_t  request channel from the upstream FIFO.
- tl_o  out  tlul_pkg::tl_d2h_t  response channel to the upstream FIFO.
- re_o  out  1  read strobe, one-cycle pulse.
- we_o  out  1  write strobe, one-cycle pulse.
- addr_o  out  RegAw  register byte address; bits [1:0] are 0.
- wdata_o  out  TL_DW  write data.
- be_o  out  TL_DBW  byte enables, equal to `a_mask`.
- rdata_i  in  TL_DW  register read data.
- error_i  in  1  register-side error; the register port sets `d_error`.

## Operation
- FSM states:
  - IDLE: `a_ready`=1.
  - WAIT: present only when AccessLatency=1.
  - RESP: `d_valid`=1.
- Request acceptance:
  - Accept when `a_valid && a_ready`, in IDLE only.
  - Accepted legal Get: `re_o`=1 for that cycle.
  - Accepted legal PutFullData/PutPartialData: `we_o`=1 for that cycle.
  - `addr_o`, `wdata_o`, `be_o` are combinational from `tl_i` and meaningful only while a strobe is high.
- Legality check. A request is illegal if any of the following holds:
  - opcode ∉ {PutFullData=0, PutPartialData=1, Get=4};
  - `a_size` > 2;
  - address misaligned for `a_size` (size 1: `addr[0]`≠0; size 2: `addr[1:0]`≠0);
  - `a_mask` has bits outside the lanes selected by size/address;
  - PutFullData `a_mask` ≠ exactly those lanes;
  - write with `a_mask`==0.
- Illegal requests:
  - Accepted normally, with no strobe.
  - Response `d_error`=1.
  - `d_data` = all-ones for Get, 0 for Puts.
- Response register, captured at accept:
  - `d_opcode` = AccessAckData for Get, AccessAck for Puts;
  - `d_size` = `a_size`; `d_source` = `a_source`;
  - `d_param`, `d_sink`, `d_user` = 0.
- Read data and error capture:
  - `d_data` = `rdata_i` and `d_error` |= `error_i`, sampled at the AccessLatency point.
  - For Puts `d_data` = 0; `error_i` is still sampled.
- Transitions:
  - IDLE→RESP on accept (AccessLatency=0), or IDLE→WAIT→RESP (AccessLatency=1).
  - RESP→IDLE on `d_valid && d_ready`.
- No same-cycle turnaround: `a_ready` depends only on state, with no combinational path from `d_ready`.

## Timing
- Reset: while `rst_i`=1 and the cycle after its release, state=IDLE.
  - During reset: `a_ready`=0, `d_valid`=0, `re_o`=`we_o`=0.
  - After reset: response fields all 0.
  - `a_ready` rises the first cycle `rst_i` is low.
- Reset mid-transaction: the response is dropped, and no strobe may fire in the reset cycle.
- Latency, accept to `d_valid`: 1 cycle (AccessLatency=0) or 2 cycles (AccessLatency=1).
- Throughput: with `d_ready` tied high, one transaction per 2 cycles (L=0) or 3 cycles (L=1).
- Backpressure:
  - `d_valid` held with all `d_*` fields stable until `d_ready`.
  - `a_ready` stays 0 throughout WAIT and RESP.
- Strobes fire exactly once per legal transaction, never in WAIT/RESP.
- `tl_i` changes while `a_ready`=0 are ignored.

## Structure
- tlul_pkg (shared package): `tl_h2d_t`/`tl_d2h_t` and the opcode enums; add `tl_a_op_e`/`tl_d_op_e` values if missing.
- Sub-module `tlul_req_chk`: purely combinational legality checker. Inputs: opcode, size, address[1:0], mask. Output: `err_o`. Reused by other device adapters.
- Adapter top level: FSM and response register only.

## Test plan
- Get at addr 0x10, size 2, mask 0xF, source 0x5A, `rdata_i`=0xDEADBEEF, L=0 → `re_o` pulse with `addr_o`=0x10; next cycle `d_valid`, AccessAckData, `d_data`=0xDEADBEEF, `d_source`=0x5A, `d_error`=0.
- Same Get with L=1, `rdata_i` changing from 0x1 to 0x2 the cycle after accept → `d_data`=0x2, `d_valid` 2 cycles after accept.
- PutPartialData addr 0x4, size 0, addr[1:0]=2, mask 0x4 → `we_o` with `be_o`=0x4; AccessAck, `d_error`=0. Same request with mask 0x1 → no `we_o`, `d_error`=1.
- Opcode 3, and Get size 2 at addr 0x2 → no strobes, `d_error`=1; the Get returns `d_data`=0xFFFFFFFF.
- `d_ready` held low 5 cycles → `d_*` stable, `a_ready`=0, no new strobes despite `a_valid`=1; accepted exactly 1 cycle after the handshake.
- `rst_i` asserted during RESP → next cycle `d_valid`=0 and `a_ready`=0; after release, IDLE with no spurious response.
